pf_ddr3_rx_lane_align: RTL and testbench

PF_DDR3_RX_LANE_ALIGN -- requirements
Module: pf_ddr3_rx_lane_align

---
 rtl/pf_ddr3_rx_lane_align_if.sv | 40 ++++
 rtl/pf_ddr3_rx_lane_align.sv | 138 +++++++++++++
 tb/tb_pf_ddr3_rx_lane_align.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pf_ddr3_rx_lane_align_if.sv
// Lane-side signal bundle for the DDR3 receive lane aligner.
// The slave modport is the aligner; the master modport drives the lane and watches results.
interface pf_ddr3_rx_lane_align_if;
    logic [7:0] rx_data_i;
    logic       rd_en_i;
    logic       train_start_i;
    logic       rx_bit_slip_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       train_busy_o;
    logic       train_done_o;
    logic       train_fail_o;
    logic [3:0] slip_count_o;

    modport slave (
        input  rx_data_i,
        input  rd_en_i,
        input  train_start_i,
        output rx_bit_slip_o,
        output rx_data_o,
        output rx_valid_o,
        output train_busy_o,
        output train_done_o,
        output train_fail_o,
        output slip_count_o
    );

    modport master (
        output rx_data_i,
        output rd_en_i,
        output train_start_i,
        input  rx_bit_slip_o,
        input  rx_data_o,
        input  rx_valid_o,
        input  train_busy_o,
        input  train_done_o,
        input  train_fail_o,
        input  slip_count_o
    );
endinterface

// File: rtl/pf_ddr3_rx_lane_align.sv
// DDR3 read-training word aligner: compares the registered lane word against the
// MPR training pattern and pulses the IOD bit-slip until enough consecutive matches lock.
module pf_ddr3_rx_lane_align #(
    parameter logic [7:0]  TRAIN_PATTERN = 8'h55,
    parameter int unsigned MATCH_CNT     = 4,
    parameter int unsigned SLIP_WAIT     = 3,
    parameter int unsigned MAX_SLIPS     = 8
) (
    input  logic                          fab_clk_i,
    input  logic                          reset_n_i,
    pf_ddr3_rx_lane_align_if.slave        lane
);

    localparam logic [3:0] MATCH_CNT_C = 4'(MATCH_CNT);
    localparam logic [3:0] SLIP_WAIT_C = 4'(SLIP_WAIT);
    localparam logic [3:0] MAX_SLIPS_C = 4'(MAX_SLIPS);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COMPARE = 3'd1,
        ST_SLIP    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_LOCKED  = 3'd4,
        ST_FAIL    = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] match_q, match_d;
    logic [3:0] wait_q, wait_d;
    logic [3:0] slip_cnt_q, slip_cnt_d;
    logic [7:0] data_q;
    logic       valid_q;
    logic       slip_q, slip_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       fail_q, fail_d;

    // Next-state and counter update for the training sequence.
    always_comb begin
        state_d    = state_q;
        match_d    = match_q;
        wait_d     = wait_q;
        slip_cnt_d = slip_cnt_q;
        case (state_q)
            ST_IDLE, ST_LOCKED, ST_FAIL: begin
                if (lane.train_start_i) begin
                    state_d    = ST_COMPARE;
                    match_d    = 4'd0;
                    wait_d     = 4'd0;
                    slip_cnt_d = 4'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_COMPARE: begin
                if (data_q == TRAIN_PATTERN) begin
                    match_d = match_q + 4'd1;
                    if ((match_q + 4'd1) == MATCH_CNT_C) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_COMPARE;
                    end
                end else begin
                    // A mismatch always wins, even on the cycle that would have locked.
                    match_d = 4'd0;
                    if (slip_cnt_q < MAX_SLIPS_C) begin
                        state_d = ST_SLIP;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_SLIP: begin
                slip_cnt_d = slip_cnt_q + 4'd1;
                wait_d     = SLIP_WAIT_C;
                match_d    = 4'd0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                match_d = 4'd0;
                if (wait_q <= 4'd1) begin
                    wait_d  = 4'd0;
                    state_d = ST_COMPARE;
                end else begin
                    wait_d  = wait_q - 4'd1;
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags are decoded from the next state so they leave a flop aligned with the state.
    always_comb begin
        slip_d = (state_d == ST_SLIP);
        busy_d = (state_d == ST_COMPARE) || (state_d == ST_SLIP) || (state_d == ST_WAIT);
        done_d = (state_d == ST_LOCKED);
        fail_d = (state_d == ST_FAIL);
    end

    // State, counters, data pipeline and status registers.
    always_ff @(posedge fab_clk_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            match_q    <= 4'd0;
            wait_q     <= 4'd0;
            slip_cnt_q <= 4'd0;
            data_q     <= 8'd0;
            valid_q    <= 1'b0;
            slip_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            match_q    <= match_d;
            wait_q     <= wait_d;
            slip_cnt_q <= slip_cnt_d;
            data_q     <= lane.rx_data_i;
            valid_q    <= lane.rd_en_i;
            slip_q     <= slip_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
        end
    end

    assign lane.rx_bit_slip_o = slip_q;
    assign lane.rx_data_o     = data_q;
    assign lane.rx_valid_o    = valid_q;
    assign lane.train_busy_o  = busy_q;
    assign lane.train_done_o  = done_q;
    assign lane.train_fail_o  = fail_q;
    assign lane.slip_count_o  = slip_cnt_q;

endmodule

// File: tb/tb_pf_ddr3_rx_lane_align.sv
// Directed bench for the lane aligner with a simple IOD bit-slip model.
module tb_pf_ddr3_rx_lane_align;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pf_ddr3_rx_lane_align_if bus ();

    pf_ddr3_rx_lane_align dut (
        .fab_clk_i (clk),
        .reset_n_i (rst_n),
        .lane      (bus.slave)
    );

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc = 0;
    int pulses = 0;
    int back2back = 0;
    int short_gap = 0;
    int last_pulse = -100;
    logic prev_slip = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock, sampled 1ns after the edge; tracks slip pulse count and spacing.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.rx_bit_slip_o === 1'b1) begin
            pulses++;
            if (prev_slip) back2back++;
            if ((cyc - last_pulse - 1) < 4) short_gap++;
            last_pulse = cyc;
        end
        prev_slip = (bus.rx_bit_slip_o === 1'b1);
    endtask

    task automatic clr_pulses();
        pulses = 0;
        back2back = 0;
        short_gap = 0;
        last_pulse = -100;
    endtask

    function automatic logic [31:0] all_outs();
        return {8'd0, bus.rx_bit_slip_o, bus.rx_data_o, bus.rx_valid_o, bus.train_busy_o,
                bus.train_done_o, bus.train_fail_o, bus.slip_count_o, 8'd0};
    endfunction

    initial begin
        int n;
        logic [7:0] pd;
        logic       pv;

        bus.rx_data_i     = 8'h00;
        bus.rd_en_i       = 1'b0;
        bus.train_start_i = 1'b0;

        // Reset state
        tick();
        tick();
        chk("reset_outs", all_outs(), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_release_outs", all_outs(), 32'd0);

        // Aligned pattern: lock after MATCH_CNT compares, no slips
        clr_pulses();
        bus.rx_data_i = 8'h55;
        bus.train_start_i = 1'b1;
        tick();
        bus.train_start_i = 1'b0;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.train_done_o || bus.train_fail_o) break;
            if (bus.train_busy_o) n++;
            tick();
        end
        chk("aligned_busy_cycles", n, 4);
        chk("aligned_done", bus.train_done_o, 1);
        chk("aligned_fail", bus.train_fail_o, 0);
        chk("aligned_slip_count", bus.slip_count_o, 0);
        chk("aligned_pulses", pulses, 0);

        // Rotated pattern, correct after 3 slips; restart from LOCKED
        clr_pulses();
        bus.rx_data_i = 8'hAA;
        bus.train_start_i = 1'b1;
        tick();
        bus.train_start_i = 1'b0;
        chk("restart_done_drop", bus.train_done_o, 0);
        chk("restart_busy", bus.train_busy_o, 1);
        chk("restart_slip_count", bus.slip_count_o, 0);
        for (int i = 0; i < 200; i++) begin
            if (bus.train_done_o || bus.train_fail_o) break;
            tick();
            bus.rx_data_i = (pulses >= 3) ? 8'h55 : 8'hAA;
        end
        chk("rot_pulses", pulses, 3);
        chk("rot_back2back", back2back, 0);
        chk("rot_short_gap", short_gap, 0);
        chk("rot_done", bus.train_done_o, 1);
        chk("rot_slip_count", bus.slip_count_o, 3);

        // Never-matching data: exhaust slips and fail
        clr_pulses();
        bus.rx_data_i = 8'h00;
        bus.train_start_i = 1'b1;
        tick();
        bus.train_start_i = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.train_done_o || bus.train_fail_o) break;
            tick();
        end
        chk("fail_pulses", pulses, 8);
        chk("fail_flag", bus.train_fail_o, 1);
        chk("fail_done", bus.train_done_o, 0);
        chk("fail_slip_count", bus.slip_count_o, 8);
        tick();
        tick();
        tick();
        chk("fail_hold_count", bus.slip_count_o, 8);
        chk("fail_hold_busy", bus.train_busy_o, 0);

        // Mismatch on the would-lock compare, then start ignored during WAIT
        clr_pulses();
        bus.rx_data_i = 8'h55;
        bus.train_start_i = 1'b1;
        tick();
        bus.train_start_i = 1'b0;
        tick();
        tick();
        bus.rx_data_i = 8'hAA;
        tick();
        bus.rx_data_i = 8'h55;
        tick();
        chk("late_mismatch_slip", bus.rx_bit_slip_o, 1);
        chk("late_mismatch_done", bus.train_done_o, 0);
        tick();
        bus.train_start_i = 1'b1;
        tick();
        bus.train_start_i = 1'b0;
        chk("wait_start_busy", bus.train_busy_o, 1);
        chk("wait_start_count", bus.slip_count_o, 1);
        for (int i = 0; i < 50; i++) begin
            if (bus.train_done_o || bus.train_fail_o) break;
            tick();
        end
        chk("late_mismatch_lock", bus.train_done_o, 1);
        chk("late_mismatch_count", bus.slip_count_o, 1);
        chk("late_mismatch_pulses", pulses, 1);

        // Reset while a slip pulse is high
        bus.rx_data_i = 8'h00;
        bus.train_start_i = 1'b1;
        tick();
        bus.train_start_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rx_bit_slip_o) break;
            tick();
        end
        chk("pre_reset_slip", bus.rx_bit_slip_o, 1);
        rst_n = 1'b0;
        tick();
        chk("mid_slip_reset_outs", all_outs(), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("reset_release_outs", all_outs(), 32'd0);
        bus.rx_data_i = 8'h55;
        bus.train_start_i = 1'b1;
        tick();
        bus.train_start_i = 1'b0;
        chk("post_reset_count", bus.slip_count_o, 0);
        for (int i = 0; i < 50; i++) begin
            if (bus.train_done_o || bus.train_fail_o) break;
            tick();
        end
        chk("post_reset_lock", bus.train_done_o, 1);
        chk("post_reset_lock_count", bus.slip_count_o, 0);

        // Data path: one-cycle latency regardless of training state
        for (int i = 0; i < 40; i++) begin
            pd = 8'($urandom_range(0, 255));
            pv = 1'($urandom_range(0, 1));
            bus.rx_data_i = pd;
            bus.rd_en_i = pv;
            bus.train_start_i = ($urandom_range(0, 7) == 0);
            tick();
            chk("pipe_data", bus.rx_data_o, pd);
            chk("pipe_valid", bus.rx_valid_o, pv);
        end
        bus.train_start_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
